wb_burst_master: RTL and testbench

WB_BURST_MASTER -- requirements
Module: wb_burst_master

---
 rtl/wb_burst_master_pkg.sv | 11 +
 rtl/wb_burst_master_if.sv | 29 ++
 rtl/wb_burst_master.sv | 147 ++++++++++++++
 tb/tb_wb_burst_master.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_burst_master_pkg.sv
// Shared Wishbone constants for the burst master: cycle-type (CTI) and
// burst-type (BTE) codes. State encoding lives in the master itself.
package wb_burst_master_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_burst_master_if.sv
// Wishbone B4 bus bundle between the burst master and a slave.
//   adr/dat_m2s/sel/we/cyc/stb/cti/bte : master -> slave
//   dat_s2m/ack/err                    : slave  -> master
interface wb_burst_master_if #(
  parameter int aw = 32,
  parameter int dw = 32
);
  logic [aw-1:0] adr;
  logic [dw-1:0] dat_m2s;
  logic [dw-1:0] dat_s2m;
  logic [3:0]    sel;
  logic          we;
  logic          cyc;
  logic          stb;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack;
  logic          err;

  modport master (
    output adr, dat_m2s, sel, we, cyc, stb, cti, bte,
    input  dat_s2m, ack, err
  );

  modport slave (
    input  adr, dat_m2s, sel, we, cyc, stb, cti, bte,
    output dat_s2m, ack, err
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone incrementing-burst master. Accepts one command (direction, start
// address, beat count) and runs it as a single linear burst on Wishbone.
//   wb_clk_i, wb_rst_i       : clock, async active-high reset
//   cmd_*                    : command handshake (ready only while idle)
//   wr_dat_i/wr_valid_i/wr_ready_o : write beat stream, consumed on ack
//   rd_dat_o/rd_valid_o      : read beat stream, one pulse per acked beat
//   done_o/err_o             : completion pulse, err_o marks a bus error
//   wb_*                     : Wishbone master signals
module wb_burst_master
  import wb_burst_master_pkg::*;
#(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int max_burst = 16,
  parameter int lw        = $clog2(max_burst) + 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [aw-1:0] cmd_adr_i,
  input  logic [lw-1:0] cmd_len_i,
  input  logic [dw-1:0] wr_dat_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  output logic [dw-1:0] rd_dat_o,
  output logic          rd_valid_o,
  output logic          done_o,
  output logic          err_o,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [lw-1:0] cnt_q, cnt_d;       // beats still to be acked
  logic          multi_q, multi_d;   // burst longer than one beat
  logic          err_q, err_d;
  logic [dw-1:0] rd_dat_q, rd_dat_d;
  logic          rd_valid_q, rd_valid_d;

  logic cyc, stb, ack_hit, err_hit;

  assign cyc     = (state_q == S_BURST);
  // Writes stall (stb low) while no write data is offered.
  assign stb     = cyc & (we_q ? wr_valid_i : 1'b1);
  // Terminations only count with stb high; err takes priority over ack.
  assign err_hit = stb & wb_err_i;
  assign ack_hit = stb & wb_ack_i & ~wb_err_i;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    adr_d      = adr_q;
    cnt_d      = cnt_q;
    multi_d    = multi_q;
    err_d      = err_q;
    rd_dat_d   = rd_dat_q;
    rd_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = {cmd_adr_i[aw-1:2], 2'b00};
          cnt_d   = cmd_len_i;
          multi_d = (cmd_len_i > lw'(1));
          err_d   = 1'b0;
          // Zero-length commands complete without touching the bus.
          state_d = (cmd_len_i == '0) ? S_DONE : S_BURST;
        end
      end
      S_BURST: begin
        if (err_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (ack_hit) begin
          adr_d = adr_q + aw'(4);
          cnt_d = cnt_q - lw'(1);
          if (!we_q) begin
            rd_dat_d   = wb_dat_i;
            rd_valid_d = 1'b1;
          end
          if (cnt_q == lw'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      adr_q      <= '0;
      cnt_q      <= '0;
      multi_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_dat_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      cnt_q      <= cnt_d;
      multi_q    <= multi_d;
      err_q      <= err_d;
      rd_dat_q   <= rd_dat_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = (state_q == S_DONE) & err_q;
  assign rd_dat_o    = rd_dat_q;
  assign rd_valid_o  = rd_valid_q;
  assign wr_ready_o  = ack_hit & we_q;

  assign wb_adr_o = adr_q;
  assign wb_dat_o = wr_dat_i;
  assign wb_sel_o = 4'hF;
  assign wb_we_o  = cyc & we_q;
  assign wb_cyc_o = cyc;
  assign wb_stb_o = stb;
  assign wb_bte_o = BTE_LINEAR;
  // Single beats are classic; longer bursts flag the final beat as END.
  assign wb_cti_o = !cyc               ? CTI_CLASSIC :
                    !multi_q           ? CTI_CLASSIC :
                    (cnt_q == lw'(1))  ? CTI_END     : CTI_INCR;

endmodule

// File: tb/tb_wb_burst_master.sv
module tb_wb_burst_master;
  import wb_burst_master_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [4:0]  cmd_len = '0;
  logic [31:0] wr_dat = '0;
  logic        wr_valid = 1'b0;
  logic        cmd_ready, wr_ready, rd_valid, done, err;
  logic [31:0] rd_dat;

  wb_burst_master_if #(.aw(32), .dw(32)) bus ();

  wb_burst_master dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len),
    .wr_dat_i(wr_dat), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_dat_o(rd_dat), .rd_valid_o(rd_valid), .done_o(done), .err_o(err),
    .wb_adr_o(bus.adr), .wb_dat_o(bus.dat_m2s), .wb_sel_o(bus.sel),
    .wb_we_o(bus.we), .wb_cyc_o(bus.cyc), .wb_stb_o(bus.stb),
    .wb_cti_o(bus.cti), .wb_bte_o(bus.bte),
    .wb_dat_i(bus.dat_s2m), .wb_ack_i(bus.ack), .wb_err_i(bus.err)
  );

  // Zero-wait-state RAM slave with error injection and stray-ack option.
  logic [31:0] mem [0:1023];
  int   beat_n = 0;
  int   err_at = 0;
  logic stray  = 1'b0;
  logic inj;
  assign inj         = (err_at != 0) && (beat_n + 1 == err_at);
  assign bus.ack     = bus.cyc & (bus.stb ? ~inj : stray);
  assign bus.err     = bus.cyc & bus.stb & inj;
  assign bus.dat_s2m = mem[bus.adr[11:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | i;
    end else if (bus.cyc && bus.stb && bus.we && bus.ack && !bus.err) begin
      mem[bus.adr[11:2]] <= bus.dat_m2s;
    end
    if (!bus.cyc) beat_n <= 0;
    else if (bus.stb && (bus.ack || bus.err)) beat_n <= beat_n + 1;
  end

  typedef struct packed {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic        we;
  } beat_t;

  beat_t       q_beat[$];
  logic [31:0] q_rd[$];
  logic        q_done[$];
  beat_t       mb;
  logic [31:0] mrd;
  logic        mdone;

  int tests = 0, fails = 0;
  int done_cnt = 0, wrrdy_cnt = 0, stbwait_cnt = 0, cyc_cnt = 0, end_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a beat/result.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cyc && bus.stb && (bus.ack || bus.err)) begin
        if (q_beat.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          mb = q_beat.pop_front();
          chk("beat_adr", bus.adr, mb.adr);
          chk("beat_cti", {29'd0, bus.cti}, {29'd0, mb.cti});
          chk("beat_we", {31'd0, bus.we}, {31'd0, mb.we});
          chk("beat_sel_bte", {26'd0, bus.sel, bus.bte}, {26'd0, 4'hF, BTE_LINEAR});
        end
        if (bus.cti == CTI_END) end_cnt++;
      end
      if (rd_valid) begin
        if (q_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          mrd = q_rd.pop_front();
          chk("rd_dat", rd_dat, mrd);
        end
      end
      if (done) begin
        done_cnt++;
        if (q_done.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          mdone = q_done.pop_front();
          chk("done_err", {31'd0, err}, {31'd0, mdone});
          chk("done_cyc_low", {31'd0, bus.cyc}, 32'd0);
        end
      end
      if (wr_ready) wrrdy_cnt++;
      if (bus.cyc && !bus.stb) stbwait_cnt++;
      if (bus.cyc) cyc_cnt++;
    end
  end

  task automatic push_beats(input logic [31:0] adr, input int n, input int total, input logic we);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.adr = adr + 32'(4 * k);
      b.cti = (total == 1) ? CTI_CLASSIC : (k == total - 1) ? CTI_END : CTI_INCR;
      b.we  = we;
      q_beat.push_back(b);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [4:0] len);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int n = 0;
    while (done_cnt == start && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == start) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic drained(input string name);
    chk({name, "_beatq"}, 32'(q_beat.size()), 0);
    chk({name, "_rdq"}, 32'(q_rd.size()), 0);
    chk({name, "_doneq"}, 32'(q_done.size()), 0);
  endtask

  initial begin
    int d0, c0, s0, w0, e0;

    // Reset state
    #12;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_cyc_stb_we", {29'd0, bus.cyc, bus.stb, bus.we}, 0);
    chk("rst_rdv_done_err", {29'd0, rd_valid, done, err}, 0);
    chk("rst_cti", {29'd0, bus.cti}, 0);
    chk("rst_adr", bus.adr, 0);
    chk("rst_rd_dat", rd_dat, 0);
    @(negedge clk); rst = 1'b0;

    // Read burst 0x100 x4
    q_beat.push_back('{32'h100, 3'b010, 1'b0});
    q_beat.push_back('{32'h104, 3'b010, 1'b0});
    q_beat.push_back('{32'h108, 3'b010, 1'b0});
    q_beat.push_back('{32'h10C, 3'b111, 1'b0});
    q_rd.push_back(32'hA500_0040); q_rd.push_back(32'hA500_0041);
    q_rd.push_back(32'hA500_0042); q_rd.push_back(32'hA500_0043);
    q_done.push_back(1'b0);
    d0 = done_cnt;
    issue(1'b0, 32'h100, 5'd4);
    wait_done(d0);
    drained("read4");

    // Write burst 0x200 x3, two-cycle data stall before beat 2 with stray acks
    push_beats(32'h200, 3, 3, 1'b1);
    q_done.push_back(1'b0);
    d0 = done_cnt; s0 = stbwait_cnt; w0 = wrrdy_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h200; cmd_len = 5'd3;
    wr_valid = 1'b1; wr_dat = 32'h1111_1111;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk); wr_valid = 1'b0; stray = 1'b1;
    @(negedge clk);
    @(negedge clk); stray = 1'b0; wr_valid = 1'b1; wr_dat = 32'h2222_2222;
    @(negedge clk); wr_dat = 32'h3333_3333;
    @(negedge clk); wr_valid = 1'b0;
    wait_done(d0);
    chk("wr_stb_wait", 32'(stbwait_cnt - s0), 2);
    chk("wr_ready_pulses", 32'(wrrdy_cnt - w0), 3);
    drained("write3");

    // Readback of the written words
    push_beats(32'h200, 3, 3, 1'b0);
    q_rd.push_back(32'h1111_1111); q_rd.push_back(32'h2222_2222);
    q_rd.push_back(32'h3333_3333);
    q_done.push_back(1'b0);
    d0 = done_cnt;
    issue(1'b0, 32'h200, 5'd3);
    wait_done(d0);
    drained("readback");

    // Single beat, unaligned address
    q_beat.push_back('{32'h000, 3'b000, 1'b0});
    q_rd.push_back(32'hA500_0000);
    q_done.push_back(1'b0);
    d0 = done_cnt;
    issue(1'b0, 32'h003, 5'd1);
    wait_done(d0);
    drained("single");

    // Error on beat 3 of 8
    err_at = 3;
    push_beats(32'h300, 3, 8, 1'b0);
    q_rd.push_back(32'hA500_00C0); q_rd.push_back(32'hA500_00C1);
    q_done.push_back(1'b1);
    d0 = done_cnt;
    issue(1'b0, 32'h300, 5'd8);
    wait_done(d0);
    err_at = 0;
    drained("error");

    // Zero length: done at T+1, no bus cycle
    q_done.push_back(1'b0);
    c0 = cyc_cnt; d0 = done_cnt;
    issue(1'b0, 32'h500, 5'd0);
    chk("len0_done_t1", {31'd0, done}, 1);
    wait_done(d0);
    chk("len0_no_cyc", 32'(cyc_cnt - c0), 0);
    drained("len0");

    // Maximum length
    push_beats(32'h400, 16, 16, 1'b0);
    for (int k = 0; k < 16; k++) q_rd.push_back(32'hA500_0100 + 32'(k));
    q_done.push_back(1'b0);
    d0 = done_cnt; e0 = end_cnt;
    issue(1'b0, 32'h400, 5'd16);
    wait_done(d0);
    chk("len16_one_end", 32'(end_cnt - e0), 1);
    drained("len16");

    // Reset during beat 2 of a 4-beat read
    push_beats(32'h100, 2, 4, 1'b0);
    q_rd.push_back(32'hA500_0040);
    d0 = done_cnt;
    issue(1'b0, 32'h100, 5'd4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cyc", {30'd0, bus.cyc, bus.stb}, 0);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 1);
    chk("mid_rst_done", {31'd0, done}, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt - d0), 0);
    chk("mid_rst_idle_cyc", {31'd0, bus.cyc}, 0);
    drained("midrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
